// File: rtl/nvm_cell_programmer_if.sv
// Request/read bus between a requester and the NVM cell programmer.
// The master drives write and read requests; the slave returns status and read data.
interface nvm_cell_programmer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output wr_req, wr_addr, wr_data, rd_en, rd_addr,
    input  busy, done, rd_data, rd_valid
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_en, rd_addr,
    output busy, done, rd_data, rd_valid
  );
endinterface

// File: rtl/nvm_cell_programmer.sv
// Erase-then-program write controller for a small NVM array, with a registered read port.
// Erase is skipped when the new value only clears bits of the stored value.
module nvm_cell_programmer #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int ERASE_CYC = 4,
  parameter int PROG_CYC  = 4
) (
  input logic                  clk,
  input logic                  rst,
  nvm_cell_programmer_if.slave bus
);

  localparam int CNT_MAX = (ERASE_CYC > PROG_CYC) ? ERASE_CYC : PROG_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(ERASE_CYC - 1);
  localparam logic [CNT_W-1:0] PROG_LOAD  = CNT_W'(PROG_CYC - 1);

  typedef enum logic [1:0] {IDLE, ERASE, PROG, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  // Array content survives reset; power-up value is the erased pattern.
  logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.wr_req) begin
            addr     <= bus.wr_addr;
            data     <= bus.wr_data;
            bus.busy <= 1'b1;
            if ((mem[bus.wr_addr] & bus.wr_data) == bus.wr_data) begin
              state <= PROG;
              cnt   <= PROG_LOAD;
            end else begin
              state <= ERASE;
              cnt   <= ERASE_LOAD;
            end
          end
        end
        ERASE: begin
          if (cnt == '0) begin
            mem[addr] <= '1;
            state     <= PROG;
            cnt       <= PROG_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PROG: begin
          if (cnt == '0) begin
            mem[addr] <= mem[addr] & data;
            state     <= DONE;
            bus.done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Nonblocking read of the array gives read-before-write on a same-edge commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rd_data <= mem[bus.rd_addr];
      end
    end
  end

endmodule

// File: doc/nvm_cell_programmer.md
# nvm_cell_programmer

Write-side controller for the 16 x 8 non-volatile memory array used across the memory blocks. It accepts single-byte write requests and runs an erase-then-program sequence on the target cell. The erase phase is skipped when programming only needs to clear bits. It also provides a registered read port, so the stored array can be read back and verified.

## Interface

Parameters:
- ADDR_W, 4, address width; the array has 2**ADDR_W cells.
- DATA_W, 8, cell width.
- ERASE_CYC, 4, cycles spent in ERASE (must be ≥ 1).
- PROG_CYC, 4, cycles spent in PROG (must be ≥ 1).

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_req  in  1  write request; sampled only in IDLE.
- wr_addr  in  ADDR_W  target cell, latched on accept.
- wr_data  in  DATA_W  value to store, latched on accept.
- busy  out  1  high from the cycle after accept through the DONE cycle.
- done  out  1  one-cycle pulse when the new value is committed.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  high the cycle after an rd_en edge.

## Operation

- States: IDLE, ERASE, PROG, DONE.
- IDLE, rd_en irrelevant, wr_req=1 at an edge:
  - latch wr_addr and wr_data.
  - If (mem[addr] & data) == data, the next state is PROG. Otherwise it is ERASE.
- IDLE, wr_req=0: stay in IDLE.
- ERASE: lasts ERASE_CYC cycles, timed by a down-counter.
  - On the last ERASE edge, mem[addr] <= all-ones and the state moves to PROG.
- PROG: lasts PROG_CYC cycles.
  - On the last PROG edge, mem[addr] <= mem[addr] & data, which equals data, and the state moves to DONE.
- DONE: one cycle with done=1, then back to IDLE.
- No command queue. wr_req in any state other than IDLE is ignored and dropped; the requester must re-present it.
- Array storage has no reset. It is non-volatile in behaviour and its power-up content is all-ones (8'hFF) via initialisation.
- Reset mid-operation:
  - the FSM returns to IDLE and the counter clears.
  - Array contents keep whatever was last committed: the old value if the erase edge was not reached, 8'hFF if the erase committed but the program did not.
- Read port:
  - On an edge with rd_en=1: rd_data <= mem[rd_addr] and rd_valid <= 1.
  - On an edge with rd_en=0: rd_valid <= 0 and rd_data holds its value.
  - Reads are allowed in every state. A read of the target cell returns the currently committed value.
- Same-edge read and commit to the same address: read-before-write; rd_data gets the pre-commit value.
- Reset values: busy=0, done=0, rd_valid=0, rd_data=0, state=IDLE.

## Timing

- Accept edge E0 (IDLE and wr_req=1) → busy=1 from E0+1.
- Path with erase:
  - ERASE occupies cycles E0+1 .. E0+ERASE_CYC; FF is committed at edge E0+ERASE_CYC.
  - PROG follows for PROG_CYC cycles; data is committed at edge E0+ERASE_CYC+PROG_CYC.
  - DONE (done=1, busy=1) is the next cycle.
- Busy duration: ERASE_CYC+PROG_CYC+1 cycles with erase, PROG_CYC+1 cycles without.
- busy falls and IDLE is reentered on the edge ending DONE. A wr_req present in that first IDLE cycle is accepted.
- A wr_req held high continuously is therefore re-accepted every (busy duration + 1) cycles.
- Read latency: 1 cycle, independent of FSM state.

## Test plan

1. Reset, then rd_en with rd_addr=3 → next cycle rd_data=8'hFF, rd_valid=1; busy=0, done=0.
2. From erased state, write addr=1, data=8'h19 → no erase; busy high 5 cycles; done pulses on the 5th; a read of addr 1 afterwards returns 8'h19.
3. Then write addr=1, data=8'h41, which needs an erase since 8'h19 & 8'h41 != 8'h41 → busy high 9 cycles. Reads of addr 1 return:
   - 8'h19 during ERASE;
   - 8'hFF during PROG;
   - 8'h41 after done.
4. During test 3, pulse wr_req with addr=2, data=8'h08 in the 3rd busy cycle → ignored; addr 2 still reads 8'hFF; only one done pulse.
5. Write addr=4, data=8'h21 over 8'h30 (erase path), and assert rst in the 2nd PROG cycle → next cycle busy=0, done=0; addr 4 reads 8'hFF; a new write to addr 4 then completes normally.
6. Hold wr_req=1 with addr=5, data=8'h08 from erased → first op takes 5 busy cycles. The second accept happens in the IDLE cycle right after DONE, takes the no-erase path, and also lasts 5 busy cycles; addr 5 reads 8'h08.
